// File: rtl/ex_mem_ovf_stage.sv
// EX/MEM pipeline register with trapping-overflow squash and a held exception request.
// The request stays pending until the exception unit acknowledges it; younger instructions become bubbles meanwhile.
module ex_mem_ovf_stage #(
    parameter int         DATA_W      = 32,
    parameter logic [4:0] EXC_CODE_OV = 5'd12,
    parameter int         CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic [DATA_W-1:0] ex_alu_res,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_overflow,
    input  logic              ex_ovf_trap,
    input  logic              exc_ack,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_pc,
    output logic [DATA_W-1:0] mem_alu_res,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [4:0]        mem_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_mem_to_reg,
    output logic              exc_req,
    output logic [DATA_W-1:0] exc_epc,
    output logic [4:0]        exc_cause,
    output logic [CNT_W-1:0]  exc_count
);

    typedef enum logic {S_IDLE, S_PEND} state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_valid;
    logic [DATA_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_alu_res;
    logic [DATA_W-1:0]   r_store_data;
    logic [4:0]          r_rd;
    logic                r_reg_write;
    logic                r_mem_read;
    logic                r_mem_write;
    logic                r_mem_to_reg;
    logic [DATA_W-1:0]   r_epc;
    logic [4:0]          r_cause;
    logic [CNT_W-1:0]    r_count;

    logic                w_trap;
    logic                w_load;
    logic                w_capture;

    assign w_trap    = ex_valid & ex_ovf_trap & ex_overflow;
    assign w_load    = ~flush & ~stall;
    assign w_capture = (r_state == S_IDLE) & w_load & w_trap;

    // FSM ignores stall and flush so an acknowledge is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_capture) w_state_nxt = S_PEND;
            S_PEND:  if (exc_ack)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_alu_res    <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (!stall) begin
            if (r_state == S_PEND) begin
                r_valid      <= 1'b0;
                r_reg_write  <= 1'b0;
                r_mem_read   <= 1'b0;
                r_mem_write  <= 1'b0;
                r_mem_to_reg <= 1'b0;
            end else begin
                r_valid      <= w_trap ? 1'b1 : ex_valid;
                r_pc         <= ex_pc;
                r_alu_res    <= ex_alu_res;
                r_store_data <= ex_store_data;
                r_rd         <= ex_rd;
                // faulting instruction keeps its slot but loses every side effect
                r_reg_write  <= ex_reg_write  & ~w_trap;
                r_mem_read   <= ex_mem_read   & ~w_trap;
                r_mem_write  <= ex_mem_write  & ~w_trap;
                r_mem_to_reg <= ex_mem_to_reg & ~w_trap;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_epc   <= '0;
            r_cause <= '0;
            r_count <= '0;
        end else if (w_capture) begin
            r_epc   <= ex_pc;
            r_cause <= EXC_CODE_OV;
            if (r_count != {CNT_W{1'b1}})
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign mem_valid      = r_valid;
    assign mem_pc         = r_pc;
    assign mem_alu_res    = r_alu_res;
    assign mem_store_data = r_store_data;
    assign mem_rd         = r_rd;
    assign mem_reg_write  = r_reg_write;
    assign mem_mem_read   = r_mem_read;
    assign mem_mem_write  = r_mem_write;
    assign mem_mem_to_reg = r_mem_to_reg;
    assign exc_req        = (r_state == S_PEND);
    assign exc_epc        = r_epc;
    assign exc_cause      = r_cause;
    assign exc_count      = r_count;

endmodule

// File: tb/tb_ex_mem_ovf_stage.sv
// Directed bench for ex_mem_ovf_stage: a reference model queues expected MEM/exception state per step.
module tb_ex_mem_ovf_stage;

    localparam int DW = 32;
    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic          stall, flush, ex_valid;
    logic [DW-1:0] ex_pc, ex_alu_res, ex_store_data;
    logic [4:0]    ex_rd;
    logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic          ex_overflow, ex_ovf_trap, exc_ack;
    logic          mem_valid;
    logic [DW-1:0] mem_pc, mem_alu_res, mem_store_data;
    logic [4:0]    mem_rd;
    logic          mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
    logic          exc_req;
    logic [DW-1:0] exc_epc;
    logic [4:0]    exc_cause;
    logic [CW-1:0] exc_count;

    ex_mem_ovf_stage #(.DATA_W(DW), .EXC_CODE_OV(5'd12), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_res(ex_alu_res),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_overflow(ex_overflow), .ex_ovf_trap(ex_ovf_trap), .exc_ack(exc_ack),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_alu_res(mem_alu_res),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
        .exc_req(exc_req), .exc_epc(exc_epc), .exc_cause(exc_cause), .exc_count(exc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc, alu, sd;
        logic [4:0]  rd;
        logic [3:0]  ctl;
        logic        req;
        logic [31:0] epc;
        logic [4:0]  cause;
        int          cnt;
    } exp_t;

    exp_t sb[$];

    int n_cmp  = 0;
    int n_fail = 0;

    logic        m_valid, m_pend;
    logic [31:0] m_pc, m_alu, m_sd, m_epc;
    logic [4:0]  m_rd, m_cause;
    logic [3:0]  m_ctl;
    int          m_cnt;

    task automatic model_reset();
        m_valid = 0; m_pend = 0; m_pc = 0; m_alu = 0; m_sd = 0; m_epc = 0;
        m_rd = 0; m_cause = 0; m_ctl = 0; m_cnt = 0;
        sb.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(mem_valid), 32'h0);
        chk({tag, "_pc"},    mem_pc, 32'h0);
        chk({tag, "_alu"},   mem_alu_res, 32'h0);
        chk({tag, "_sd"},    mem_store_data, 32'h0);
        chk({tag, "_rd"},    32'(mem_rd), 32'h0);
        chk({tag, "_ctl"},   32'({mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}), 32'h0);
        chk({tag, "_req"},   32'(exc_req), 32'h0);
        chk({tag, "_epc"},   exc_epc, 32'h0);
        chk({tag, "_cause"}, 32'(exc_cause), 32'h0);
        chk({tag, "_cnt"},   32'(exc_count), 32'h0);
    endtask

    // ctl = {reg_write, mem_read, mem_write, mem_to_reg}
    task automatic step(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [4:0] rd, input logic [3:0] ctl, input logic ovf, input logic tr,
                        input logic fl, input logic st, input logic ack);
        exp_t e;
        exp_t g;
        logic trap;
        ex_valid = v; ex_pc = pc; ex_alu_res = alu; ex_store_data = alu ^ 32'hA5A5_A5A5;
        ex_rd = rd; {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} = ctl;
        ex_overflow = ovf; ex_ovf_trap = tr; flush = fl; stall = st; exc_ack = ack;
        trap = v & tr & ovf;
        if (fl) begin
            m_valid = 0; m_ctl = 0;
        end else if (!st) begin
            if (m_pend) begin
                m_valid = 0; m_ctl = 0;
            end else if (trap) begin
                m_valid = 1; m_pc = pc; m_alu = alu; m_rd = rd; m_ctl = 0;
            end else begin
                m_valid = v; m_pc = pc; m_alu = alu; m_sd = alu ^ 32'hA5A5_A5A5; m_rd = rd; m_ctl = ctl;
            end
        end
        if (m_pend) begin
            if (ack) m_pend = 0;
        end else if (!fl && !st && trap) begin
            m_pend = 1; m_epc = pc; m_cause = 5'd12;
            if (m_cnt < 3) m_cnt++;
        end
        e.valid = m_valid; e.pc = m_pc; e.alu = m_alu; e.sd = m_sd; e.rd = m_rd; e.ctl = m_ctl;
        e.req = m_pend; e.epc = m_epc; e.cause = m_cause; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk({tag, "_valid"}, 32'(mem_valid), 32'(g.valid));
        chk({tag, "_ctl"}, 32'({mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}), 32'(g.ctl));
        if (g.valid) begin
            chk({tag, "_pc"},  mem_pc, g.pc);
            chk({tag, "_alu"}, mem_alu_res, g.alu);
            chk({tag, "_rd"},  32'(mem_rd), 32'(g.rd));
        end
        if (g.ctl[1]) chk({tag, "_sd"}, mem_store_data, g.sd);
        chk({tag, "_req"},   32'(exc_req), 32'(g.req));
        chk({tag, "_epc"},   exc_epc, g.epc);
        chk({tag, "_cause"}, 32'(exc_cause), 32'(g.cause));
        chk({tag, "_cnt"},   32'(exc_count), 32'(g.cnt));
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0; ex_valid = 0; ex_pc = 0; ex_alu_res = 0; ex_store_data = 0;
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
        ex_overflow = 0; ex_ovf_trap = 0; exc_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst0");
        #1 rst = 0;

        step("norm", 1, 32'h40, 32'h1234_5678, 5'd5, 4'b1000, 0, 0, 0, 0, 0);
        chk("norm_alu_k", mem_alu_res, 32'h1234_5678);
        step("store", 1, 32'h44, 32'h0000_2000, 5'd0, 4'b0010, 0, 0, 0, 0, 0);

        step("trap", 1, 32'h100, 32'h8000_0000, 5'd3, 4'b1000, 1, 1, 0, 0, 0);
        chk("trap_rw_k", 32'(mem_reg_write), 32'h0);
        chk("trap_req_k", 32'(exc_req), 32'h1);
        chk("trap_epc_k", exc_epc, 32'h100);
        chk("trap_cause_k", 32'(exc_cause), 32'd12);
        chk("trap_cnt_k", 32'(exc_count), 32'd1);
        step("young1", 1, 32'h104, 32'h11, 5'd6, 4'b1000, 0, 0, 0, 0, 0);
        step("young2", 1, 32'h108, 32'h22, 5'd7, 4'b1100, 0, 0, 0, 0, 1);
        chk("ack_req_k", 32'(exc_req), 32'h0);
        step("resume", 1, 32'h180, 32'h33, 5'd8, 4'b1000, 0, 0, 0, 0, 0);
        chk("resume_valid_k", 32'(mem_valid), 32'h1);

        step("addu", 1, 32'h184, 32'h8000_0000, 5'd9, 4'b1000, 1, 0, 0, 0, 0);
        chk("addu_rw_k", 32'(mem_reg_write), 32'h1);
        step("novld", 0, 32'h188, 32'h44, 5'd10, 4'b1000, 1, 1, 0, 0, 0);

        step("trapfl", 1, 32'h18C, 32'h55, 5'd11, 4'b1000, 1, 1, 1, 0, 0);
        chk("trapfl_req_k", 32'(exc_req), 32'h0);
        step("trapst", 1, 32'h190, 32'h66, 5'd12, 4'b1000, 1, 1, 0, 1, 0);
        step("trapst2", 1, 32'h190, 32'h66, 5'd12, 4'b1000, 1, 1, 0, 0, 0);
        chk("trapst2_req_k", 32'(exc_req), 32'h1);
        chk("trapst2_epc_k", exc_epc, 32'h190);
        step("pendfl", 1, 32'h194, 32'h77, 5'd13, 4'b1000, 0, 0, 1, 0, 0);
        step("pendst", 1, 32'h198, 32'h88, 5'd14, 4'b1000, 0, 0, 0, 1, 0);
        step("pendstack", 1, 32'h198, 32'h88, 5'd14, 4'b1000, 0, 0, 0, 1, 1);
        step("idle2", 1, 32'h198, 32'h88, 5'd14, 4'b0011, 0, 0, 0, 0, 0);

        step("b2b1", 1, 32'h200, 32'h99, 5'd15, 4'b1000, 1, 1, 0, 0, 0);
        step("b2b2", 1, 32'h204, 32'hAA, 5'd16, 4'b1000, 1, 1, 0, 0, 0);
        chk("b2b_epc_k", exc_epc, 32'h200);
        chk("b2b_cnt_k", 32'(exc_count), 32'd3);

        // asynchronous reset while a request is pending
        #3 rst = 1;
        #1 chk_zero("arst");
        #2 rst = 0;
        model_reset();

        for (int i = 0; i < 4; i++) begin
            step("sat_trap", 1, 32'h300 + 32'(i * 4), 32'h7FFF_FFFF, 5'd1, 4'b1000, 1, 1, 0, 0, 0);
            chk("sat_cnt_k", 32'(exc_count), (i < 3) ? 32'(i + 1) : 32'd3);
            step("sat_ack", 0, 32'h0, 32'h0, 5'd0, 4'b0000, 0, 0, 0, 0, 1);
        end
        step("final", 1, 32'h400, 32'hBEEF, 5'd2, 4'b1001, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_ovf_stage.md
Name: ex_mem_ovf_stage

Overview:
- EX/MEM pipeline register of the 5-stage CPU, placed directly downstream of the EX-stage overflow detector and ALU.
- Latches EX results and control into the MEM stage.
- On a trapping arithmetic overflow, squashes the faulting instruction's side effects and raises an overflow exception request (EPC, cause).
- Holds that request until the exception unit acknowledges it, and converts all younger instructions into bubbles while the request is pending.

Parameters:
DATA_W, 32, width of PC, ALU result and store data
EXC_CODE_OV, 5'd12, cause code reported for arithmetic overflow
CNT_W, 8, width of the saturating overflow-exception counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
stall  in  1  hold MEM-stage register contents
flush  in  1  load a bubble into the MEM stage
ex_valid  in  1  EX stage holds a real instruction
ex_pc  in  DATA_W  PC of EX instruction
ex_alu_res  in  DATA_W  ALU result
ex_store_data  in  DATA_W  rt value for stores
ex_rd  in  5  destination register
ex_reg_write  in  1  register write enable
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_mem_to_reg  in  1  writeback selects memory data
ex_overflow  in  1  overflow flag from EX overflow detector
ex_ovf_trap  in  1  instruction traps on overflow (add/sub/addi; 0 for addu/subu/slt)
exc_ack  in  1  exception unit accepted the request
mem_valid, mem_pc, mem_alu_res, mem_store_data, mem_rd, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  out  (as matching ex_*)  registered MEM-stage copies
exc_req  out  1  overflow exception pending
exc_epc  out  DATA_W  PC of faulting instruction
exc_cause  out  5  cause code
exc_count  out  CNT_W  saturating count of raised overflow exceptions

Behaviour:
- Reset (async, immediate):
  - All mem_* outputs = 0.
  - exc_req = 0, exc_epc = 0, exc_cause = 0, exc_count = 0.
  - FSM = IDLE.
- trap = ex_valid & ex_ovf_trap & ex_overflow.
- Register update priority each edge: rst > flush > stall > load.
  - flush: bubble, i.e. mem_valid and all mem_* control enables = 0; data fields may keep old values.
  - stall: all mem_* hold their values; trap is not evaluated (the instruction has not advanced).
  - load in IDLE, trap = 0: copy all ex_* to mem_*; 1-cycle latency.
  - load in IDLE, trap = 1:
    - mem_valid = 1, mem_pc/mem_alu_res/mem_rd loaded.
    - mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg forced to 0.
    - exc_epc <= ex_pc, exc_cause <= EXC_CODE_OV, exc_count increments (saturates at all-ones).
    - FSM -> PEND.
  - load in PEND: bubble loaded (younger instruction killed); trap ignored, exc_epc/count unchanged.
- FSM:
  - IDLE: exc_req = 0; exc_ack ignored.
  - PEND: exc_req = 1; exc_epc and exc_cause stable. exc_ack = 1 -> IDLE at the next edge. The instruction arriving in the ack cycle is still squashed.
- exc_req is registered; it asserts in the cycle after the faulting instruction's EX cycle.
- Boundaries:
  - ex_overflow with ex_ovf_trap = 0: normal load with write enables intact; no exception.
  - ex_overflow with ex_valid = 0: ignored.
  - flush in the same cycle as trap: flush wins, no exception raised.
  - flush or stall while PEND: FSM stays PEND, exc_req held.
  - stall together with exc_ack in PEND: ack still honoured (FSM is independent of stall).
  - Back-to-back traps in IDLE: only the first is captured; the second arrives while PEND and is squashed.
  - rst mid-PEND: request dropped, counter cleared.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately, before the next clk edge.
- Normal flow: ex_valid=1, pc=0x40, alu_res=0x12345678, rd=5, reg_write=1, no overflow -> next cycle mem_alu_res=0x12345678, mem_rd=5, mem_reg_write=1, exc_req=0.
- Trapping overflow: add 0x7FFFFFFF+1, ex_overflow=1, ex_ovf_trap=1, pc=0x100 -> next cycle mem_reg_write=0, exc_req=1, exc_epc=0x100, exc_cause=12, exc_count=1. The following two instructions arrive with mem_valid=0. exc_ack pulse -> exc_req=0 one cycle later; the next instruction loads normally.
- Non-trapping overflow: addu with ex_overflow=1, ex_ovf_trap=0 -> mem_reg_write=1, exc_req stays 0.
- Priority: trap with flush=1 -> bubble, exc_req=0. Trap with stall=1 -> no exception until stall drops; then exc_req=1 on the cycle after release.
- Saturation: CNT_W=2, four trap/ack sequences -> exc_count reads 1, 2, 3, 3.
